// File: rtl/filtr_pkg.sv
// filtr_pkg: widths, alpha constants, saturation limits and FSM state type
// shared by the adaptive-alpha IIR smoother (filtr_alpha_top).
package filtr_pkg;

   localparam int unsigned DATA_SIZE = 25;
   localparam int unsigned COEF_SIZE = 25;

   localparam int unsigned SMP_W  = DATA_SIZE - 1;          // I/O sample width
   localparam int unsigned ERR_W  = DATA_SIZE;              // x - y_prev width
   localparam int unsigned PROD_W = DATA_SIZE + COEF_SIZE;  // e * alpha width
   localparam int unsigned FRAC_W = COEF_SIZE - 1;          // alpha fraction bits

   // alpha is unsigned Q0.(COEF_SIZE-1)
   localparam logic [COEF_SIZE-1:0] ALPHA_INIT = COEF_SIZE'(1) << (COEF_SIZE - 4);
   localparam logic [COEF_SIZE-1:0] ALPHA_MIN  = COEF_SIZE'(1) << (COEF_SIZE - 7);
   localparam logic [COEF_SIZE-1:0] ALPHA_MAX  = COEF_SIZE'(1) << (COEF_SIZE - 2);
   localparam logic [COEF_SIZE-1:0] ALPHA_STEP = COEF_SIZE'(1) << (COEF_SIZE - 6);
   localparam logic [ERR_W-1:0]     ERR_THRESH = ERR_W'(4096);

   // Output range of the accumulator and the round-half-up bias
   localparam logic signed [PROD_W-1:0] SAT_MAX =
      $signed((PROD_W'(1) << (DATA_SIZE - 2)) - PROD_W'(1));
   localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [PROD_W-1:0] RND_K   = $signed(PROD_W'(1) << (COEF_SIZE - 2));

   typedef enum logic [2:0] {IDLE, ERR, MUL, ACC, OUT} state_t;

   // Magnitude of a signed error; the most-negative code maps to the largest positive one
   function automatic logic [ERR_W-1:0] abs_sat(input logic [ERR_W-1:0] v);
      logic [ERR_W-1:0] r;
      if (!v[ERR_W-1])
         r = v;
      else if (v[ERR_W-2:0] == '0)
         r = {1'b0, {(ERR_W-1){1'b1}}};
      else
         r = -v;
      return r;
   endfunction

endpackage

// File: rtl/filtr_alpha_adapt.sv
// filtr_alpha_adapt: next-alpha selection from the error magnitude.
// Present only when FILTR_ALPHA_ADAPT_EN is defined.
`ifdef FILTR_ALPHA_ADAPT_EN
module filtr_alpha_adapt
   import filtr_pkg::*;
(
   input  logic [ERR_W-1:0]     i_err,
   input  logic [COEF_SIZE-1:0] i_alpha,
   output logic [COEF_SIZE-1:0] o_alpha
);

   logic [ERR_W-1:0]   w_mag;
   logic [COEF_SIZE:0] w_up;
   logic [COEF_SIZE:0] w_dn_lim;

   // Large error speeds tracking up, small error slows it down, both clamped
   always_comb begin
      w_mag    = abs_sat(i_err);
      w_up     = {1'b0, i_alpha} + {1'b0, ALPHA_STEP};
      w_dn_lim = {1'b0, ALPHA_MIN} + {1'b0, ALPHA_STEP};
      o_alpha  = i_alpha;
      if (w_mag > ERR_THRESH)
         o_alpha = (w_up > {1'b0, ALPHA_MAX}) ? ALPHA_MAX : w_up[COEF_SIZE-1:0];
      else
         o_alpha = ({1'b0, i_alpha} < w_dn_lim) ? ALPHA_MIN : (i_alpha - ALPHA_STEP);
   end

endmodule
`endif

// File: rtl/filtr_alpha_top.sv
// filtr_alpha_top: adaptive first-order IIR smoother, y += alpha * (x - y),
// computed over ERR/MUL/ACC/OUT cycles after each accepted sample.
// Define FILTR_ALPHA_ADAPT_EN to let alpha follow the error magnitude;
// otherwise alpha stays at ALPHA_INIT.
module filtr_alpha_top
   import filtr_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [SMP_W-1:0] data_in,
   input  logic             sample,
   output logic [SMP_W-1:0] data_out,
   output logic             filter_done
);

   state_t                   r_state;
   logic [SMP_W-1:0]         r_x;
   logic [SMP_W-1:0]         r_y;
   logic [SMP_W-1:0]         r_s;
   logic signed [ERR_W-1:0]  r_e;
   logic signed [PROD_W-1:0] r_p;

   logic [COEF_SIZE-1:0]     w_alpha;
   logic signed [ERR_W-1:0]  w_err;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [PROD_W-1:0] w_rnd;
   logic signed [PROD_W-1:0] w_d;
   logic signed [PROD_W-1:0] w_sum;
   logic [SMP_W-1:0]         w_sat;

`ifdef FILTR_ALPHA_ADAPT_EN
   logic [COEF_SIZE-1:0] r_alpha;
   logic [COEF_SIZE-1:0] w_alpha_next;

   assign w_alpha = r_alpha;

   filtr_alpha_adapt u_adapt (
      .i_err   (r_e),
      .i_alpha (r_alpha),
      .o_alpha (w_alpha_next)
   );
`else
   assign w_alpha = ALPHA_INIT;
`endif

   // Step arithmetic: error, product, rounded increment and saturated sum
   always_comb begin
      w_err  = $signed({r_x[SMP_W-1], r_x}) - $signed({r_y[SMP_W-1], r_y});
      w_prod = $signed({{COEF_SIZE{r_e[ERR_W-1]}}, r_e}) *
               $signed({{DATA_SIZE{1'b0}}, w_alpha});
      w_rnd  = r_p + RND_K;
      w_d    = w_rnd >>> FRAC_W;
      w_sum  = $signed({{(PROD_W-SMP_W){r_y[SMP_W-1]}}, r_y}) + w_d;
      if (w_sum > SAT_MAX)
         w_sat = SAT_MAX[SMP_W-1:0];
      else if (w_sum < SAT_MIN)
         w_sat = SAT_MIN[SMP_W-1:0];
      else
         w_sat = w_sum[SMP_W-1:0];
   end

   // Sequencer: one datapath step per clock, registered result and done strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_s         <= '0;
         r_e         <= '0;
         r_p         <= '0;
         data_out    <= '0;
         filter_done <= 1'b0;
`ifdef FILTR_ALPHA_ADAPT_EN
         r_alpha     <= ALPHA_INIT;
`endif
      end else begin
         filter_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (sample) begin
                  r_x     <= data_in;
                  r_state <= ERR;
               end
            end
            ERR: begin
               r_e     <= w_err;
               r_state <= MUL;
            end
            MUL: begin
               r_p     <= w_prod;
               r_state <= ACC;
            end
            ACC: begin
               r_s     <= w_sat;
               r_state <= OUT;
            end
            OUT: begin
               data_out    <= r_s;
               r_y         <= r_s;
               filter_done <= 1'b1;
`ifdef FILTR_ALPHA_ADAPT_EN
               r_alpha     <= w_alpha_next;
`endif
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_filtr_alpha_top.sv
// tb_filtr_alpha_top: directed and randomized checks of filtr_alpha_top
// against an arithmetic reference of the smoother (alpha as an integer
// numerator over 2^24). Honours FILTR_ALPHA_ADAPT_EN like the design.
module tb_filtr_alpha_top;

   localparam longint Q      = 64'sd16777216;   // alpha == 1.0
   localparam longint A_INIT = Q / 8;
   localparam longint A_MIN  = Q / 64;
   localparam longint A_MAX  = Q / 2;
   localparam longint A_STEP = Q / 32;
   localparam longint THRESH = 4096;
   localparam longint Y_HI   = 8388607;
   localparam longint Y_LO   = -8388608;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] data_in;
   logic        sample;
   logic [23:0] data_out;
   logic        filter_done;

   int n_chk = 0;
   int n_err = 0;

   // reference state
   longint m_y, m_a, m_out, m_pend, m_pend_a;
   int     m_cnt;
   logic   m_done;

   filtr_alpha_top dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .sample      (sample),
      .data_out    (data_out),
      .filter_done (filter_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   // y + alpha*(x-y), rounded half up, clamped to the 24-bit range
   function automatic longint ref_out(input longint x, input longint y, input longint a);
      longint s;
      s = y + floor_div((x - y) * a + Q / 2, Q);
      if (s > Y_HI) s = Y_HI;
      if (s < Y_LO) s = Y_LO;
      return s;
   endfunction

   function automatic longint ref_alpha(input longint e, input longint a);
`ifdef FILTR_ALPHA_ADAPT_EN
      longint mag;
      mag = (e < 0) ? -e : e;
      if (mag > THRESH) return (a + A_STEP > A_MAX) ? A_MAX : a + A_STEP;
      else              return (a - A_STEP < A_MIN) ? A_MIN : a - A_STEP;
`else
      if (e == 0) return a;
      return a;
`endif
   endfunction

   task automatic model_reset();
      m_y = 0; m_a = A_INIT; m_out = 0; m_done = 1'b0;
      m_cnt = 0; m_pend = 0; m_pend_a = A_INIT;
   endtask

   // A sample is accepted when idle; its result appears four edges later
   task automatic model_edge();
      longint x;
      m_done = 1'b0;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_out  = m_pend;
            m_y    = m_pend;
            m_a    = m_pend_a;
            m_done = 1'b1;
         end
      end else if (sample) begin
         x        = longint'($signed(data_in));
         m_pend   = ref_out(x, m_y, m_a);
         m_pend_a = ref_alpha(x - m_y, m_a);
         m_cnt    = 4;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_reset();
      else        model_edge();
      @(negedge clk);
      check("done", longint'(filter_done), longint'(m_done));
      check("dout", longint'($signed(data_out)), m_out);
   endtask

   task automatic do_reset();
      reset = 1'b0; sample = 1'b0;
      tick(); tick();
      reset = 1'b1;
   endtask

   // one-cycle request followed by four idle-request cycles up to the result
   task automatic pulse(input logic [23:0] v);
      data_in = v; sample = 1'b1;
      tick();
      sample = 1'b0;
      repeat (4) tick();
      check("pulse_done", longint'(filter_done), 1);
   endtask

   function automatic longint dout_s();
      return longint'($signed(data_out));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      longint prev, cur, t;
      int     dones, mode;
      logic [23:0] v;

      // reset held with sample high
      reset = 1'b0; sample = 1'b1; data_in = 24'h000001;
      model_reset();
      repeat (3) tick();
      check("rst_dout", dout_s(), 0);
      check("rst_done", longint'(filter_done), 0);
      reset = 1'b1;
      tick();
      sample = 1'b0;
      repeat (4) tick();
      check("rel_done", longint'(filter_done), 1);

      // small input: increments round to zero, alpha decays
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pulse(24'h000001);
         check("t2_zero", dout_s(), 0);
         tick();
      end
      pulse(24'h100000);
`ifdef FILTR_ALPHA_ADAPT_EN
      check("t2_amin", dout_s(), 16384);
`else
      check("t2_amin", dout_s(), 131072);
`endif

      // step response
      do_reset();
      pulse(24'h100000);
      check("t3_first", dout_s(), 131072);
      pulse(24'h100000);
`ifdef FILTR_ALPHA_ADAPT_EN
      check("t3_second", dout_s(), 274432);
`else
      check("t3_second", dout_s(), 245760);
`endif

      // threshold edge: |e| == 4096 shrinks alpha, 4097 grows it
      do_reset();
      pulse(24'd4096);
      pulse(24'h100000);
`ifdef FILTR_ALPHA_ADAPT_EN
      check("thr_eq", dout_s(), 98768);
`else
      check("thr_eq", dout_s(), 131520);
`endif
      do_reset();
      pulse(24'd4097);
      pulse(24'h100000);
`ifdef FILTR_ALPHA_ADAPT_EN
      check("thr_gt", dout_s(), 164272);
`else
      check("thr_gt", dout_s(), 131520);
`endif

      // full-scale inputs: monotonic, bounded
      do_reset();
      prev = 0;
      for (int i = 0; i < 12; i++) begin
         pulse(24'h7FFFFF);
         cur = dout_s();
         check("t4_mono_up", longint'(cur >= prev), 1);
         check("t4_le_max", longint'(cur <= Y_HI), 1);
         prev = cur;
      end
      for (int i = 0; i < 8; i++) begin
         pulse(24'h800000);
         cur = dout_s();
         check("t4_mono_dn", longint'(cur <= prev), 1);
         check("t4_ge_min", longint'(cur >= Y_LO), 1);
         prev = cur;
      end
      check("t4_neg", longint'(prev < 0), 1);

      // sample held high: one result every five cycles
      do_reset();
      dones = 0;
      sample = 1'b1;
      for (int i = 0; i < 25; i++) begin
         data_in = 24'($urandom);
         tick();
         if (filter_done) dones++;
      end
      sample = 1'b0;
      check("t5_cnt", longint'(dones), 5);

      // reset while in MUL aborts the run
      do_reset();
      tick();
      data_in = 24'h100000; sample = 1'b1;
      tick();
      sample = 1'b0;
      tick();
      reset = 1'b0;
      dones = 0;
      repeat (4) begin
         tick();
         if (filter_done) dones++;
      end
      check("t6_nodone", longint'(dones), 0);
      reset = 1'b1;
      tick();
      pulse(24'h100000);
      check("t6_restart", dout_s(), 131072);

      // randomized traffic, including requests while busy and rare resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset  = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
         sample = ($urandom_range(0, 2) == 0);
         mode   = int'($urandom_range(0, 3));
         case (mode)
            0: v = 24'($urandom);
            1: begin
               t = longint'($urandom_range(0, 8191)) - 4096;
               v = t[23:0];
            end
            2: begin
               t = longint'($urandom_range(4095, 4097));
               t = ($urandom_range(0, 1) == 0) ? m_y + t : m_y - t;
               if (t > Y_HI) t = Y_HI;
               if (t < Y_LO) t = Y_LO;
               v = t[23:0];
            end
            default: v = ($urandom_range(0, 1) == 0) ? 24'h7FFFFF : 24'h800000;
         endcase
         data_in = v;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
